// File: rtl/memory_ctrl.sv
// ============================================================================
// Module   : memory_ctrl
// Purpose  : CPU data-access decoder (user/video/keyboard) and cache-line
//            refill sequencer. Optional macro KEYBOARD_EN enables the KEY region.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_ctrl #(
   parameter int          ADDR_W     = 20,
   parameter int          LINE_WORDS = 4,
   parameter logic [31:0] VIDEO_BASE = 32'hF0000000,
   parameter int          VIDEO_SIZE = 1500,
   parameter logic [31:0] KEY_ADDR   = 32'hFFFFFFFF
) (
   input  logic        CLK_cpu,
   input  logic        reset,
   input  logic        mem_en,
   input  logic [1:0]  store_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] write_data,
   input  logic [31:0] next_PC,
   input  logic        icache_miss,
   input  logic        dcache_miss,
   input  logic [31:0] dcache_rdata,
   output logic        dcache_read_en,
   output logic        dcache_write_en,
   output logic [31:0] dcache_write_data,
   output logic        icache_fill_we,
   output logic        dcache_fill_we,
   output logic [31:0] fill_addr,
   output logic [31:0] fill_data,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   input  logic [31:0] bus_rdata,
   input  logic        bus_valid,
   input  logic [7:0]  pressed_key,
   output logic        clean_key_buffer,
   output logic        video_write_enable,
   output logic [7:0]  video_write_data,
   output logic [10:0] video_write_addr,
   output logic [31:0] read_data,
   output logic        stall,
   output logic        access_err
);

   localparam int               c_CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int               c_OFF_W     = $clog2(LINE_WORDS) + 2;
   localparam logic [31:0]      c_LINE_MASK = ~((32'd1 << c_OFF_W) - 32'd1);
   localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL_D = 2'd1,
      S_FILL_I = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [c_CNT_W-1:0]   r_word_cnt, w_cnt_nxt;
   logic [31:0]          r_line_base, w_base_nxt;
   logic                 r_access_err;

   logic        w_user, w_video, w_key;
   logic [32:0] w_addr_ext;
   logic        w_load, w_byte, w_accept, w_err, w_fill;

   // Region decode; USER takes precedence, then VIDEO, then KEY.
   assign w_addr_ext = {1'b0, mem_addr};
   assign w_user     = (mem_addr[31:ADDR_W] == '0);
   assign w_video    = !w_user && (w_addr_ext >= {1'b0, VIDEO_BASE})
                       && (w_addr_ext < ({1'b0, VIDEO_BASE} + 33'(VIDEO_SIZE)));

`ifdef KEYBOARD_EN
   assign w_key = !w_user && !w_video && (mem_addr == KEY_ADDR);
`else
   logic w_unused_key;
   assign w_key        = 1'b0;
   assign w_unused_key = ^{pressed_key, (mem_addr == KEY_ADDR)};
`endif

   assign w_load   = (store_size == 2'b11);
   assign w_byte   = (store_size == 2'b00);
   assign w_accept = mem_en && !stall && !reset;
   assign w_err    = !w_user && !(w_video && w_byte) && !(w_key && w_load);

   assign dcache_read_en     = w_accept && w_user && w_load;
   assign dcache_write_en    = w_accept && w_user && !w_load;
   assign dcache_write_data  = write_data;
   assign video_write_enable = w_accept && w_video && w_byte;
   assign video_write_data   = write_data[7:0];
   assign video_write_addr   = mem_addr[10:0] - VIDEO_BASE[10:0];

`ifdef KEYBOARD_EN
   assign clean_key_buffer = w_accept && w_key && w_load;
`else
   assign clean_key_buffer = 1'b0;
`endif

   always_comb begin
      read_data = 32'd0;
      if (w_user)
         read_data = dcache_rdata;
      else if (w_key)
         read_data = {24'd0, pressed_key};
   end

   assign bus_req        = (r_state != S_IDLE);
   assign bus_addr       = r_line_base + {{(32-c_CNT_W-2){1'b0}}, r_word_cnt, 2'b00};
   assign stall          = bus_req || dcache_miss || icache_miss;
   assign w_fill         = bus_req && bus_valid && !reset;
   assign dcache_fill_we = w_fill && (r_state == S_FILL_D);
   assign icache_fill_we = w_fill && (r_state == S_FILL_I);
   assign fill_addr      = bus_addr;
   assign fill_data      = bus_rdata;
   assign access_err     = r_access_err;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_word_cnt;
      w_base_nxt  = r_line_base;
      case (r_state)
         S_IDLE: begin
            if (dcache_miss) begin
               w_state_nxt = S_FILL_D;
               w_base_nxt  = mem_addr & c_LINE_MASK;
               w_cnt_nxt   = '0;
            end else if (icache_miss) begin
               w_state_nxt = S_FILL_I;
               w_base_nxt  = next_PC & c_LINE_MASK;
               w_cnt_nxt   = '0;
            end
         end
         S_FILL_D, S_FILL_I: begin
            if (bus_valid) begin
               if (r_word_cnt == c_LAST) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_word_cnt + c_CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK_cpu) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_word_cnt   <= '0;
         r_line_base  <= 32'd0;
         r_access_err <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_word_cnt   <= w_cnt_nxt;
         r_line_base  <= w_base_nxt;
         r_access_err <= w_accept && w_err;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_memory_ctrl.sv
// ============================================================================
// Module   : tb_memory_ctrl
// Purpose  : Directed plus randomized self-checking bench for memory_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_memory_ctrl;

   localparam int          ADDR_W = 20;
   localparam int          LW     = 4;
   localparam logic [31:0] VB     = 32'hF0000000;
   localparam int          VS     = 1500;
   localparam logic [31:0] KA     = 32'hFFFFFFFF;

   logic        CLK_cpu, reset, mem_en;
   logic [1:0]  store_size;
   logic [31:0] mem_addr, write_data, next_PC, dcache_rdata, bus_rdata;
   logic        icache_miss, dcache_miss, bus_valid;
   logic [7:0]  pressed_key;
   logic        dcache_read_en, dcache_write_en, icache_fill_we, dcache_fill_we;
   logic [31:0] dcache_write_data, fill_addr, fill_data, bus_addr, read_data;
   logic        bus_req, clean_key_buffer, video_write_enable, stall, access_err;
   logic [7:0]  video_write_data;
   logic [10:0] video_write_addr;

   memory_ctrl #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .VIDEO_BASE(VB),
                 .VIDEO_SIZE(VS), .KEY_ADDR(KA)) dut (
      .CLK_cpu(CLK_cpu), .reset(reset), .mem_en(mem_en), .store_size(store_size),
      .mem_addr(mem_addr), .write_data(write_data), .next_PC(next_PC),
      .icache_miss(icache_miss), .dcache_miss(dcache_miss), .dcache_rdata(dcache_rdata),
      .dcache_read_en(dcache_read_en), .dcache_write_en(dcache_write_en),
      .dcache_write_data(dcache_write_data), .icache_fill_we(icache_fill_we),
      .dcache_fill_we(dcache_fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_rdata(bus_rdata), .bus_valid(bus_valid),
      .pressed_key(pressed_key), .clean_key_buffer(clean_key_buffer),
      .video_write_enable(video_write_enable), .video_write_data(video_write_data),
      .video_write_addr(video_write_addr), .read_data(read_data), .stall(stall),
      .access_err(access_err)
   );

   initial CLK_cpu = 1'b0;
   always #5 CLK_cpu = ~CLK_cpu;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: which line is being fetched and how many words arrived.
   int          m_kind = 0;     // 0 none, 1 data line, 2 instruction line
   logic [31:0] m_base = 32'd0;
   int          m_idx  = 0;
   logic        m_err  = 1'b0;

   logic        e_stall, e_acc, e_errc;
   int          e_reg;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // 0 user, 1 video, 2 keyboard, 3 unmapped
   function automatic int region(input logic [31:0] a);
      if (longint'(a) < (longint'(1) << ADDR_W)) return 0;
      if (a >= VB && longint'(a) < longint'(VB) + VS) return 1;
`ifdef KEYBOARD_EN
      if (a == KA) return 2;
`endif
      return 3;
   endfunction

   task automatic model_eval();
      logic ld, by;
      ld      = (store_size == 2'b11);
      by      = (store_size == 2'b00);
      e_reg   = region(mem_addr);
      e_stall = (m_kind != 0) || dcache_miss || icache_miss;
      e_acc   = mem_en && !e_stall && !reset;
      e_errc  = (e_reg == 3) || (e_reg == 1 && !by) || (e_reg == 2 && !ld);
   endtask

   task automatic settle_check();
      logic        ld, by, fd, fi;
      logic [31:0] rd;
      #1;
      model_eval();
      ld = (store_size == 2'b11);
      by = (store_size == 2'b00);
      rd = (e_reg == 0) ? dcache_rdata : (e_reg == 2) ? {24'd0, pressed_key} : 32'd0;
      fd = (m_kind == 1) && bus_valid && !reset;
      fi = (m_kind == 2) && bus_valid && !reset;
      check("stall", stall, e_stall);
      check("bus_req", bus_req, m_kind != 0);
      check("access_err", access_err, m_err);
      check("dcache_read_en", dcache_read_en, e_acc && e_reg == 0 && ld);
      check("dcache_write_en", dcache_write_en, e_acc && e_reg == 0 && !ld);
      check("dcache_write_data", dcache_write_data, write_data);
      check("video_we", video_write_enable, e_acc && e_reg == 1 && by);
      check("clean_key", clean_key_buffer, e_acc && e_reg == 2 && ld);
      check("read_data", read_data, rd);
      check("dcache_fill_we", dcache_fill_we, fd);
      check("icache_fill_we", icache_fill_we, fi);
      if (e_acc && e_reg == 1 && by) begin
         check("video_addr", video_write_addr, (mem_addr - VB) % 2048);
         check("video_data", video_write_data, write_data % 256);
      end
      if (m_kind != 0)
         check("bus_addr", bus_addr, m_base + 4 * m_idx);
      if (fd || fi) begin
         check("fill_addr", fill_addr, m_base + 4 * m_idx);
         check("fill_data", fill_data, bus_rdata);
      end
   endtask

   task automatic tick();
      logic [31:0] line_bytes;
      line_bytes = 4 * LW;
      model_eval();
      @(posedge CLK_cpu);
      if (reset) begin
         m_kind = 0; m_idx = 0; m_err = 1'b0;
      end else begin
         m_err = e_acc && e_errc;
         if (m_kind == 0) begin
            if (dcache_miss) begin
               m_kind = 1; m_idx = 0; m_base = (mem_addr / line_bytes) * line_bytes;
            end else if (icache_miss) begin
               m_kind = 2; m_idx = 0; m_base = (next_PC / line_bytes) * line_bytes;
            end
         end else if (bus_valid) begin
            m_idx++;
            if (m_idx == LW) begin m_kind = 0; m_idx = 0; end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; mem_en = 1'b0; store_size = 2'b11; mem_addr = 32'd0;
      write_data = 32'd0; next_PC = 32'd0; icache_miss = 1'b0; dcache_miss = 1'b0;
      dcache_rdata = 32'd0; bus_rdata = 32'd0; bus_valid = 1'b0; pressed_key = 8'd0;
   endtask

   int n_fill;

   initial begin
      idle_inputs();
      reset = 1'b1;
      @(posedge CLK_cpu); #1;
      @(posedge CLK_cpu); #1;
      settle_check();
      tick();
      reset = 1'b0;

      // user load, no miss
      mem_en = 1'b1; store_size = 2'b11; mem_addr = 32'h100; dcache_rdata = $urandom;
      settle_check();
      check("r021_read_en", dcache_read_en, 1);
      check("r021_rdata", read_data, dcache_rdata);
      tick();

      // video byte store
      store_size = 2'b00; mem_addr = 32'hF0000005;
      write_data = ($urandom & 32'hFFFFFF00) | 32'h41;
      settle_check();
      check("r022_we", video_write_enable, 1);
      check("r022_addr", video_write_addr, 5);
      check("r022_data", video_write_data, 32'h41);
      tick();

      // illegal accesses: word store to video, then unmapped load
      store_size = 2'b10; mem_addr = 32'hF0000000;
      settle_check();
      check("r024_no_video", video_write_enable, 0);
      check("r024_no_err_yet", access_err, 0);
      tick();
      store_size = 2'b11; mem_addr = 32'h10000000;
      settle_check();
      check("r024_err1", access_err, 1);
      check("r024_no_read", dcache_read_en, 0);
      tick();
      mem_en = 1'b0;
      settle_check();
      check("r024_err2", access_err, 1);
      tick();
      settle_check();
      check("r024_err_clear", access_err, 0);
      tick();

      // simultaneous misses: data line first, then instruction line
      mem_en = 1'b1; store_size = 2'b11; mem_addr = 32'h234; next_PC = 32'h1008;
      dcache_miss = 1'b1; icache_miss = 1'b1;
      settle_check();
      tick();
      n_fill = 0;
      for (int w = 0; w < 4; w++) begin
         bus_valid = 1'b0;
         settle_check();
         check("r023_bus_addr", bus_addr, 32'h230 + 4 * w);
         tick();
         bus_valid = 1'b1; bus_rdata = $urandom;
         settle_check();
         if (dcache_fill_we === 1'b1) n_fill++;
         tick();
      end
      bus_valid = 1'b0; dcache_miss = 1'b0;
      check("r023_fill_count", n_fill, 4);
      settle_check();
      check("r023_idle_req", bus_req, 0);
      tick();
      settle_check();
      check("r023_ifill_addr", bus_addr, 32'h1000);
      for (int w = 0; w < 4; w++) begin
         bus_valid = 1'b1; bus_rdata = $urandom;
         settle_check();
         check("r023_ifill_we", icache_fill_we, 1);
         tick();
      end
      bus_valid = 1'b0; icache_miss = 1'b0;
      settle_check();
      tick();

      // reset in the middle of an instruction line fill
      mem_en = 1'b0; icache_miss = 1'b1; next_PC = 32'h2044;
      settle_check();
      tick();
      for (int w = 0; w < 2; w++) begin
         bus_valid = 1'b1; bus_rdata = $urandom;
         settle_check();
         tick();
      end
      bus_valid = 1'b0; reset = 1'b1;
      settle_check();
      tick();
      reset = 1'b0;
      settle_check();
      check("r025_req", bus_req, 0);
      tick();
      settle_check();
      check("r025_refetch", bus_addr, 32'h2040);
      for (int w = 0; w < 4; w++) begin
         bus_valid = 1'b1; bus_rdata = $urandom;
         settle_check();
         tick();
      end
      bus_valid = 1'b0; icache_miss = 1'b0;
      settle_check();
      tick();

      // keyboard load
      mem_en = 1'b1; store_size = 2'b11; mem_addr = 32'hFFFFFFFF; pressed_key = 8'h1C;
      settle_check();
`ifdef KEYBOARD_EN
      check("r026_rdata", read_data, 32'h1C);
      check("r026_clean", clean_key_buffer, 1);
`else
      check("r026_rdata_off", read_data, 0);
      check("r026_clean_off", clean_key_buffer, 0);
`endif
      tick();
      mem_en = 1'b0;
      settle_check();
      check("r026_clean_drop", clean_key_buffer, 0);
      tick();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 5))
            0, 1: mem_addr = $urandom & ((32'd1 << ADDR_W) - 1);
            2:    mem_addr = VB + $urandom_range(0, VS - 1);
            3:    mem_addr = ($urandom & 1) ? VB + VS : VB - 1;
            4:    mem_addr = KA;
            default: mem_addr = $urandom;
         endcase
         mem_en       = ($urandom % 4) != 0;
         store_size   = 2'($urandom);
         write_data   = $urandom;
         next_PC      = $urandom;
         dcache_miss  = ($urandom % 8) == 0;
         icache_miss  = ($urandom % 8) == 0;
         bus_valid    = $urandom & 1;
         bus_rdata    = $urandom;
         dcache_rdata = $urandom;
         pressed_key  = 8'($urandom);
         reset        = ($urandom % 64) == 0;
         settle_check();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
